// File: rtl/vx_fpu_fma_issue.sv
// vx_fpu_fma_issue: issue stage in front of the DSP FMA unit.
// Requests pass through a 2-entry elastic buffer, and a credit counter caps
// the number of outstanding FMA operations.
// Ports:
//   clk, reset (async, active-high)
//   request in : valid_in/ready_in, mask_in, tag_in, frm, is_madd, is_sub,
//                is_neg, dataa, datab, datac
//   to FMA     : fma_valid/fma_ready, fma_mask, fma_tag, fma_frm,
//                fma_is_madd, fma_is_sub, fma_is_neg,
//                fma_dataa, fma_datab, fma_datac
//   response   : rsp_fire (one pulse per completed operation)
//   status     : inflight, busy, err_underflow
//   perf       : perf_credit_stalls, perf_bp_stalls
// Build option: FPU_FMA_ISSUE_PERF_EN enables the two stall counters.
// When it is undefined, both perf ports read 0 and no counters are built.
module vx_fpu_fma_issue #(
   parameter int  NUM_LANES    = 4,
   parameter int  TAG_WIDTH    = 8,
   parameter int  MAX_INFLIGHT = 8,
   localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      valid_in,
   output logic                      ready_in,
   input  logic [NUM_LANES-1:0]      mask_in,
   input  logic [TAG_WIDTH-1:0]      tag_in,
   input  logic [2:0]                frm,
   input  logic                      is_madd,
   input  logic                      is_sub,
   input  logic                      is_neg,
   input  logic [NUM_LANES*32-1:0]   dataa,
   input  logic [NUM_LANES*32-1:0]   datab,
   input  logic [NUM_LANES*32-1:0]   datac,
   output logic                      fma_valid,
   input  logic                      fma_ready,
   output logic [NUM_LANES-1:0]      fma_mask,
   output logic [TAG_WIDTH-1:0]      fma_tag,
   output logic [2:0]                fma_frm,
   output logic                      fma_is_madd,
   output logic                      fma_is_sub,
   output logic                      fma_is_neg,
   output logic [NUM_LANES*32-1:0]   fma_dataa,
   output logic [NUM_LANES*32-1:0]   fma_datab,
   output logic [NUM_LANES*32-1:0]   fma_datac,
   input  logic                      rsp_fire,
   output logic [CW-1:0]             inflight,
   output logic                      busy,
   output logic                      err_underflow,
   output logic [31:0]               perf_credit_stalls,
   output logic [31:0]               perf_bp_stalls
);

   localparam int DW = NUM_LANES * 32;
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_INFLIGHT);

   typedef struct packed {
      logic [NUM_LANES-1:0] mask;
      logic [TAG_WIDTH-1:0] tag;
      logic [2:0]           frm;
      logic                 is_madd;
      logic                 is_sub;
      logic                 is_neg;
      logic [DW-1:0]        a;
      logic [DW-1:0]        b;
      logic [DW-1:0]        c;
   } req_t;

   req_t          mem [2];
   req_t          wr_req;
   req_t          head;
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic [1:0]    count_nxt;
   logic          ready_q;
   logic [CW-1:0] inflight_q;
   logic [CW-1:0] inflight_nxt;
   logic          err_q;
   logic          empty;
   logic          credit_ok;
   logic          push;
   logic          issue;
   logic          rsp_dec;
   logic          underflow;

   assign empty     = (count == 2'd0);
   assign credit_ok = (inflight_q < MAXC);
   assign fma_valid = !empty && credit_ok;
   assign issue     = fma_valid && fma_ready;
   assign push      = valid_in && ready_q;
   assign rsp_dec   = rsp_fire && (inflight_q != '0);
   assign underflow = rsp_fire && (inflight_q == '0) && !issue;

   assign wr_req = '{
      mask:    mask_in,
      tag:     tag_in,
      frm:     frm,
      is_madd: is_madd,
      is_sub:  is_sub,
      is_neg:  is_neg,
      a:       dataa,
      b:       datab,
      c:       datac
   };

   always_comb begin
      count_nxt = count;
      unique case (1'b1)
         push && !issue: count_nxt = count + 2'd1;
         !push && issue: count_nxt = count - 2'd1;
         default: ;
      endcase
   end

   always_comb begin
      inflight_nxt = inflight_q;
      unique case (1'b1)
         issue && !rsp_dec: inflight_nxt = inflight_q + ONE;
         !issue && rsp_dec: inflight_nxt = inflight_q - ONE;
         default: ;
      endcase
   end

   // Payload storage carries no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_req;
      end
   end

   // ready_q is a flop so ready_in never depends on fma_ready, and it
   // stays low during reset until the first edge after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         ready_q    <= 1'b0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= !wr_ptr;
         end
         if (issue) begin
            rd_ptr <= !rd_ptr;
         end
         count      <= count_nxt;
         ready_q    <= (count_nxt != 2'd2);
         inflight_q <= inflight_nxt;
         err_q      <= err_q | underflow;
      end
   end

   assign head = mem[rd_ptr];

   assign ready_in      = ready_q;
   assign fma_mask      = head.mask;
   assign fma_tag       = head.tag;
   assign fma_frm       = head.frm;
   assign fma_is_madd   = head.is_madd;
   assign fma_is_sub    = head.is_sub;
   assign fma_is_neg    = head.is_neg;
   assign fma_dataa     = head.a;
   assign fma_datab     = head.b;
   assign fma_datac     = head.c;
   assign inflight      = inflight_q;
   assign busy          = !empty || (inflight_q != '0);
   assign err_underflow = err_q;

`ifdef FPU_FMA_ISSUE_PERF_EN
   logic [31:0] cstall_q;
   logic [31:0] bpstall_q;
   logic        cstall;
   logic        bpstall;

   assign cstall  = !empty && (inflight_q == MAXC);
   assign bpstall = fma_valid && !fma_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cstall_q  <= '0;
         bpstall_q <= '0;
      end else begin
         if (cstall) begin
            cstall_q <= cstall_q + 32'd1;
         end
         if (bpstall) begin
            bpstall_q <= bpstall_q + 32'd1;
         end
      end
   end

   assign perf_credit_stalls = cstall_q;
   assign perf_bp_stalls     = bpstall_q;
`else
   assign perf_credit_stalls = '0;
   assign perf_bp_stalls     = '0;
`endif

endmodule

// File: tb/tb_vx_fpu_fma_issue.sv
// tb_vx_fpu_fma_issue: directed bench for vx_fpu_fma_issue.
// Covers streaming, credit limit, backpressure, underflow and async reset.
module tb_vx_fpu_fma_issue;

   localparam int NL = 4;
   localparam int TW = 8;
   localparam int MI = 8;
   localparam int CW = $clog2(MI + 1);

   logic            clk = 1'b0;
   logic            reset;
   logic            valid_in;
   logic            ready_in;
   logic [NL-1:0]   mask_in;
   logic [TW-1:0]   tag_in;
   logic [2:0]      frm;
   logic            is_madd;
   logic            is_sub;
   logic            is_neg;
   logic [NL*32-1:0] dataa;
   logic [NL*32-1:0] datab;
   logic [NL*32-1:0] datac;
   logic            fma_valid;
   logic            fma_ready;
   logic [NL-1:0]   fma_mask;
   logic [TW-1:0]   fma_tag;
   logic [2:0]      fma_frm;
   logic            fma_is_madd;
   logic            fma_is_sub;
   logic            fma_is_neg;
   logic [NL*32-1:0] fma_dataa;
   logic [NL*32-1:0] fma_datab;
   logic [NL*32-1:0] fma_datac;
   logic            rsp_fire;
   logic [CW-1:0]   inflight;
   logic            busy;
   logic            err_underflow;
   logic [31:0]     perf_credit_stalls;
   logic [31:0]     perf_bp_stalls;

   vx_fpu_fma_issue #(
      .NUM_LANES    (NL),
      .TAG_WIDTH    (TW),
      .MAX_INFLIGHT (MI)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .valid_in           (valid_in),
      .ready_in           (ready_in),
      .mask_in            (mask_in),
      .tag_in             (tag_in),
      .frm                (frm),
      .is_madd            (is_madd),
      .is_sub             (is_sub),
      .is_neg             (is_neg),
      .dataa              (dataa),
      .datab              (datab),
      .datac              (datac),
      .fma_valid          (fma_valid),
      .fma_ready          (fma_ready),
      .fma_mask           (fma_mask),
      .fma_tag            (fma_tag),
      .fma_frm            (fma_frm),
      .fma_is_madd        (fma_is_madd),
      .fma_is_sub         (fma_is_sub),
      .fma_is_neg         (fma_is_neg),
      .fma_dataa          (fma_dataa),
      .fma_datab          (fma_datab),
      .fma_datac          (fma_datac),
      .rsp_fire           (rsp_fire),
      .inflight           (inflight),
      .busy               (busy),
      .err_underflow      (err_underflow),
      .perf_credit_stalls (perf_credit_stalls),
      .perf_bp_stalls     (perf_bp_stalls)
   );

   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;

   task automatic check(input string tag,
                        input logic [127:0] got,
                        input logic [127:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] opnd(input logic [7:0] t,
                                         input logic [3:0] k);
      return {k, 4'h3, 16'h0, t, k, 4'h2, 16'h0, t,
              k, 4'h1, 16'h0, t, k, 4'h0, 16'h0, t};
   endfunction

   task automatic set_req(input logic [7:0] t);
      tag_in  = t;
      mask_in = t[3:0];
      frm     = t[2:0];
      is_madd = t[0];
      is_sub  = t[1];
      is_neg  = t[2];
      dataa   = opnd(t, 4'hA);
      datab   = opnd(t, 4'hB);
      datac   = opnd(t, 4'hC);
   endtask

   task automatic chk_head(input string tag, input logic [7:0] t);
      check({tag, "_tag"},   fma_tag, t);
      check({tag, "_mask"},  fma_mask, t[3:0]);
      check({tag, "_frm"},   fma_frm, t[2:0]);
      check({tag, "_flags"},
            {fma_is_madd, fma_is_sub, fma_is_neg}, {t[0], t[1], t[2]});
      check({tag, "_a"},     fma_dataa, opnd(t, 4'hA));
      check({tag, "_b"},     fma_datab, opnd(t, 4'hB));
      check({tag, "_c"},     fma_datac, opnd(t, 4'hC));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      rsp_fire = 1'b0;
      reset    = 1'b1;
      #3;
      reset    = 1'b0;
      step();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         rsp_fire = (inflight != '0);
         #1;
         if (!busy) break;
         step();
      end
      rsp_fire = 1'b0;
      check(tag, busy, 0);
      check({tag, "_noerr"}, err_underflow, 0);
   endtask

   bit hist [64];
   int sent, got, first, last, peak, issued, cstall, acc;

   initial begin
      reset     = 1'b0;
      valid_in  = 1'b0;
      fma_ready = 1'b0;
      rsp_fire  = 1'b0;
      set_req(8'h00);
      #1 reset = 1'b1;
      #1;
      check("rst_ready_in", ready_in, 0);
      check("rst_fma_valid", fma_valid, 0);
      check("rst_inflight", inflight, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_underflow, 0);
      check("rst_perf_c", perf_credit_stalls, 0);
      check("rst_perf_bp", perf_bp_stalls, 0);
      #2 reset = 1'b0;
      step();
      check("rdy_after_rst", ready_in, 1);

      // Streaming: responses return 4 cycles after each issue.
      fma_ready = 1'b1;
      sent = 0; got = 0; first = -1; last = -1; peak = 0;
      for (int c = 0; c < 40; c++) begin
         valid_in = (sent < 16);
         set_req(8'(sent));
         rsp_fire = (c >= 4) ? hist[c-4] : 1'b0;
         #1;
         if (int'(inflight) > peak) peak = int'(inflight);
         hist[c] = fma_valid && fma_ready;
         if (hist[c]) begin
            chk_head("stream", 8'(got));
            if (first < 0) first = c;
            last = c;
            got++;
         end
         if (valid_in && ready_in) sent++;
         step();
      end
      valid_in = 1'b0;
      rsp_fire = 1'b0;
      check("stream_count", got, 16);
      check("stream_b2b", last - first, 15);
      check("stream_peak", peak, 4);
      check("stream_idle", busy, 0);

      // Credit limit with no responses.
      do_reset();
      fma_ready = 1'b1;
      sent = 0; issued = 0; cstall = 0;
      for (int c = 0; c < 16; c++) begin
         valid_in = (sent < 10);
         set_req(8'(8'h20 + sent));
         #1;
         if ((sent - issued) > 0 && issued == MI) cstall++;
         if (fma_valid && fma_ready) begin
            check("credit_order", fma_tag, 8'(8'h20 + issued));
            issued++;
         end
         if (valid_in && ready_in) sent++;
         step();
      end
      valid_in = 1'b0;
      #1;
      check("credit_issued", issued, 8);
      check("credit_sent", sent, 10);
      check("credit_inflight", inflight, 8);
      check("credit_valid", fma_valid, 0);
      check("credit_ready_in", ready_in, 0);
`ifdef FPU_FMA_ISSUE_PERF_EN
      check("credit_perf", perf_credit_stalls, cstall);
`else
      check("credit_perf_off", perf_credit_stalls, 0);
`endif
      rsp_fire = 1'b1;
      #1;
      check("credit_rsp_cyc", fma_valid, 0);
      step();
      rsp_fire = 1'b0;
      #1;
      check("credit_reissue", fma_valid, 1);
      check("credit_9th", fma_tag, 8'h28);
      check("credit_infl7", inflight, 7);
      step();
      #1;
      check("credit_infl8", inflight, 8);
      drain("credit_drain");

      // Backpressure: FMA not ready for 5 valid cycles.
      do_reset();
      fma_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         valid_in = (acc < 3);
         set_req(8'(8'h30 + acc));
         #1;
         if (fma_valid) chk_head("bp_hold", 8'h30);
         if (valid_in && ready_in) acc++;
         step();
      end
      check("bp_accepted", acc, 2);
      check("bp_ready_in", ready_in, 0);
`ifdef FPU_FMA_ISSUE_PERF_EN
      check("bp_perf", perf_bp_stalls, 5);
`else
      check("bp_perf_off", perf_bp_stalls, 0);
`endif
      valid_in  = 1'b0;
      fma_ready = 1'b1;
      #1;
      check("bp_rel0_v", fma_valid, 1);
      check("bp_rel0", fma_tag, 8'h30);
      step();
      check("bp_rel1_v", fma_valid, 1);
      check("bp_rel1", fma_tag, 8'h31);
      step();
      check("bp_infl", inflight, 2);
      drain("bp_drain");

      // Simultaneous issue and response hold inflight steady.
      do_reset();
      fma_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         valid_in = 1'b1;
         set_req(8'(8'h40 + k));
         #1;
         step();
      end
      check("sim_start", inflight, 3);
      for (int k = 0; k < 6; k++) begin
         set_req(8'(8'h44 + k));
         rsp_fire = 1'b1;
         #1;
         check("sim_issue", fma_valid, 1);
         step();
         check("sim_infl", inflight, 3);
      end
      valid_in = 1'b0;
      rsp_fire = 1'b0;
      drain("sim_drain");

      // Underflow is sticky and leaves inflight at 0.
      do_reset();
      check("uf_pre", err_underflow, 0);
      rsp_fire = 1'b1;
      #1;
      step();
      rsp_fire = 1'b0;
      check("uf_set", err_underflow, 1);
      check("uf_infl", inflight, 0);
      step();
      step();
      step();
      check("uf_sticky", err_underflow, 1);
      check("uf_infl_hold", inflight, 0);

      // Async reset mid-cycle with buffer full and inflight = 5.
      do_reset();
      check("ar_uf_clr", err_underflow, 0);
      fma_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         valid_in = 1'b1;
         set_req(8'(8'h50 + k));
         #1;
         step();
      end
      fma_ready = 1'b0;
      set_req(8'h56);
      #1;
      step();
      valid_in = 1'b0;
      check("ar_pre_infl", inflight, 5);
      check("ar_pre_full", ready_in, 0);
      check("ar_pre_valid", fma_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("ar_valid", fma_valid, 0);
      check("ar_infl", inflight, 0);
      check("ar_busy", busy, 0);
      check("ar_ready", ready_in, 0);
      #1 reset = 1'b0;
      #1;
      check("ar_ready_pre_edge", ready_in, 0);
      step();
      check("ar_ready_post", ready_in, 1);
      check("ar_busy_post", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/vx_fpu_fma_issue.md
Name: vx_fpu_fma_issue

Overview:
- Issue stage directly upstream of the DSP FMA unit; takes FMA/ADD/SUB/MUL requests from the FPU dispatcher.
- Holds requests in a 2-entry elastic buffer so that `ready_in` is registered and has no combinational path from the FMA's ready.
- Limits outstanding FMA operations with a credit counter. The counter decrements when the FMA's valid/ready response handshake completes (`rsp_fire`).
- Passes operands, op flags, mask, tag and rounding mode through unmodified and in order.

Parameters:
- NUM_LANES, 4, lanes per request.
- TAG_WIDTH, 8, request tag width.
- MAX_INFLIGHT, 8, maximum issued-but-not-responded operations (>=1). Counter width is $clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  request valid.
- ready_in  out  1  request accepted when valid_in && ready_in.
- mask_in  in  NUM_LANES  active lanes.
- tag_in  in  TAG_WIDTH  request tag.
- frm  in  3  rounding mode.
- is_madd, is_sub, is_neg  in  1 each  op select flags.
- dataa, datab, datac  in  NUM_LANES*32 each  operands.
- fma_valid  out  1  request to FMA.
- fma_ready  in  1  FMA accepts.
- fma_mask, fma_tag, fma_frm, fma_is_madd, fma_is_sub, fma_is_neg, fma_dataa, fma_datab, fma_datac  out  widths as inputs  buffered request.
- rsp_fire  in  1  FMA output handshake completed, one pulse per operation.
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding count.
- busy  out  1  buffer non-empty or inflight != 0.
- err_underflow  out  1  sticky error flag.
- perf_credit_stalls, perf_bp_stalls  out  32 each  performance counters.

Behaviour:
- Reset (async, high):
  - Buffer empty; inflight=0; err_underflow=0; perf counters=0.
  - fma_valid=0 and ready_in=0 while reset is high.
  - ready_in=1 from the first clock edge after deassert.
- Buffer: 2-entry FIFO, registered count.
  - ready_in = !full. It is computed from registered state only.
  - In a full cycle, ready_in stays 0 even if an issue fires that same cycle.
  - Enqueue on valid_in && ready_in. Payload = {mask, tag, frm, flags, a, b, c}.
- Latency and throughput:
  - Request accepted at edge N is visible on fma_* after edge N (next cycle).
  - Sustained throughput is 1 request per cycle when fma_ready=1 and credits are available.
- Issue:
  - fma_valid = !empty && (inflight < MAX_INFLIGHT).
  - issue = fma_valid && fma_ready. On issue, pop the head.
  - fma_* outputs hold stable while fma_valid=1 && !fma_ready.
- Credits (inflight):
  - next inflight = inflight + issue - (rsp_fire && inflight != 0).
  - issue and rsp_fire in the same cycle leave inflight unchanged.
  - At inflight == MAX_INFLIGHT, fma_valid is 0. A rsp_fire in that cycle re-enables issue on the next cycle.
- Underflow: rsp_fire with inflight==0 and no issue that cycle:
  - inflight stays 0.
  - err_underflow latches to 1 until reset.
- Ordering: strict FIFO; no reordering or dropping. mask_in==0 requests are queued and issued like any other.
- busy = !empty || inflight != 0.
- Reset mid-operation: all queued and in-flight state is discarded immediately. The outputs return to their reset values without waiting for a clock edge.

Optional Feature:
- Macro FPU_FMA_ISSUE_PERF_EN.
- Defined:
  - perf_credit_stalls increments each cycle with !empty && inflight==MAX_INFLIGHT.
  - perf_bp_stalls increments each cycle with fma_valid && !fma_ready.
  - Both are 32-bit, wrap modulo 2^32, cleared by reset.
- Not defined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- Back-to-back stream, fma_ready=1, MAX_INFLIGHT=8 with rsp_fire 4 cycles after each issue:
  - 16 requests, tags 0..15, issue on consecutive cycles, tags in order.
  - Data/mask/frm bit-exact; inflight peaks at 4.
- Credit limit: no rsp_fire, 10 requests:
  - Exactly 8 issue, inflight=8, fma_valid=0, ready_in=0 after the buffer fills.
  - With PERF_EN, perf_credit_stalls counts every stalled cycle.
  - One rsp_fire pulse -> the 9th request issues on the next cycle.
- Backpressure: fma_ready=0 for 5 cycles with 3 requests offered:
  - 2 accepted; ready_in=0; fma_* stable; perf_bp_stalls=5 (PERF_EN).
  - Releasing fma_ready -> tags issue in order.
- Simultaneous issue and rsp_fire for 6 cycles with inflight=3 -> inflight stays 3 throughout.
- Underflow: rsp_fire with inflight=0 -> err_underflow=1 and stays 1; inflight stays 0.
- Async reset asserted mid-cycle with buffer full and inflight=5:
  - fma_valid=0, inflight=0, busy=0 immediately, before the next edge.
  - ready_in=1 one edge after reset deasserts.
